// File: rtl/dtree_walker_seq.sv
// Table-driven decision-tree classifier.
// Walks one node of a runtime-loaded node table per cycle over a latched
// feature vector, then presents the class (or an abort flag) with valid/ready.
module dtree_walker_seq #(
    parameter int N_FEAT    = 16,
    parameter int FEAT_W    = 8,
    parameter int CLASS_W   = 4,
    parameter int N_NODES   = 32,
    parameter int NODE_AW   = 5,
    parameter int FIDX_W    = 4,
    parameter int MAX_DEPTH = 8,
    localparam int NW       = 1 + FIDX_W + FEAT_W + 2*NODE_AW
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cfg_we,
    input  logic [NODE_AW-1:0]       i_cfg_addr,
    input  logic [NW-1:0]            i_cfg_data,
    output logic                     o_cfg_busy,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] i_in_feats,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [CLASS_W-1:0]       o_out_class,
    output logic                     o_out_err
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    // Node word field offsets, LSB upward: right, left, thresh, feat_idx, is_leaf
    localparam int OFS_R    = 0;
    localparam int OFS_L    = NODE_AW;
    localparam int OFS_THR  = 2*NODE_AW;
    localparam int OFS_FIDX = 2*NODE_AW + FEAT_W;
    localparam int OFS_LEAF = NW - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                          r_state, w_state_nxt;
    logic [NW-1:0]                   r_node [N_NODES];
    logic [N_FEAT-1:0][FEAT_W-1:0]   r_feats;
    logic [NODE_AW-1:0]              r_ptr, w_ptr_nxt;
    logic [DEPTH_W-1:0]              r_depth, w_depth_nxt;
    logic                            r_out_valid, w_out_valid_nxt;
    logic [CLASS_W-1:0]              r_out_class, w_out_class_nxt;
    logic                            r_out_err, w_out_err_nxt;
    logic                            w_latch;

    // Current node decode
    logic [NW-1:0]                   w_node;
    logic                            w_is_leaf;
    logic [FIDX_W-1:0]               w_fidx;
    logic [FEAT_W-1:0]               w_thr;
    logic [NODE_AW-1:0]              w_left, w_right;
    logic [FEAT_W-1:0]               w_feat_sel;
    logic                            w_ptr_bad, w_fidx_bad, w_addr_bad;
    logic                            w_depth_max;
    logic                            w_cfg_wr;

    // Range guards only exist when the field width can encode illegal values;
    // with power-of-two sizes they collapse to constant zero.
    generate
        if (N_NODES < (1 << NODE_AW)) begin : g_node_guard
            assign w_ptr_bad  = (r_ptr >= NODE_AW'(N_NODES));
            assign w_addr_bad = (i_cfg_addr >= NODE_AW'(N_NODES));
        end else begin : g_node_noguard
            assign w_ptr_bad  = 1'b0;
            assign w_addr_bad = 1'b0;
        end
        if (N_FEAT < (1 << FIDX_W)) begin : g_fidx_guard
            assign w_fidx_bad = (w_fidx >= FIDX_W'(N_FEAT));
        end else begin : g_fidx_noguard
            assign w_fidx_bad = 1'b0;
        end
    endgenerate

    // An out-of-range pointer reads as zero and is flagged as an error below
    assign w_node      = w_ptr_bad ? '0 : r_node[r_ptr];
    assign w_is_leaf   = w_node[OFS_LEAF];
    assign w_fidx      = w_node[OFS_FIDX +: FIDX_W];
    assign w_thr       = w_node[OFS_THR  +: FEAT_W];
    assign w_left      = w_node[OFS_L    +: NODE_AW];
    assign w_right     = w_node[OFS_R    +: NODE_AW];
    assign w_feat_sel  = w_fidx_bad ? '0 : r_feats[w_fidx];
    assign w_depth_max = (r_depth == DEPTH_W'(MAX_DEPTH - 1));
    assign w_cfg_wr    = i_cfg_we && (r_state == S_IDLE) && !w_addr_bad;

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_cfg_busy  = (r_state != S_IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_class = r_out_class;
    assign o_out_err   = r_out_err;

    // Node table: cleared on reset, writable only while idle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_NODES; i++) r_node[i] <= '0;
        end else if (w_cfg_wr) begin
            r_node[i_cfg_addr] <= i_cfg_data;
        end
    end

    // State, walk pointer, depth, result and feature latch registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_depth     <= '0;
            r_out_valid <= 1'b0;
            r_out_class <= '0;
            r_out_err   <= 1'b0;
            r_feats     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_depth     <= w_depth_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_class <= w_out_class_nxt;
            r_out_err   <= w_out_err_nxt;
            if (w_latch) r_feats <= i_in_feats;
        end
    end

    // Next-state logic: accept in IDLE, one node per WALK cycle, hold result in DONE.
    // out_valid rises on the edge after DONE is entered and drops on handshake.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_depth_nxt     = r_depth;
        w_out_valid_nxt = r_out_valid;
        w_out_class_nxt = r_out_class;
        w_out_err_nxt   = r_out_err;
        w_latch         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_out_valid_nxt = 1'b0;
                if (i_in_valid) begin
                    w_latch     = 1'b1;
                    w_ptr_nxt   = '0;
                    w_depth_nxt = '0;
                    w_state_nxt = S_WALK;
                end
            end
            S_WALK: begin
                if (!w_ptr_bad && w_is_leaf) begin
                    w_out_class_nxt = w_thr[CLASS_W-1:0];
                    w_out_err_nxt   = 1'b0;
                    w_state_nxt     = S_DONE;
                end else if (w_ptr_bad || w_fidx_bad || w_depth_max) begin
                    w_out_class_nxt = '0;
                    w_out_err_nxt   = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_ptr_nxt   = (w_feat_sel <= w_thr) ? w_left : w_right;
                    w_depth_nxt = r_depth + DEPTH_W'(1);
                end
            end
            S_DONE: begin
                if (r_out_valid && i_out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_out_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule
